// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for the 5-stage core.
// Ports: clk, reset (async, active-low); D/E source regs rsD/rtD/rsE/rtE;
//   writereg*/RegWrite* for E/M/W; MemtoRegE/M; branchD; divE/div_done;
//   mem_req/mem_data_ok; excM. Outputs: div_start/div_cancel/mem_timeout
//   pulses, stallF..W, flushD..W, forwardaE/bE (2b), forwardaD/bD (1b).
// Build option: define HAZARD_FWD_EN to enable the bypass network;
//   without it every RAW dependency on D is resolved by stalling.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       branchD,
  input  logic       divE,
  input  logic       div_done,
  input  logic       mem_req,
  input  logic       mem_data_ok,
  input  logic       excM,
  output logic       div_start,
  output logic       div_cancel,
  output logic       mem_timeout,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic [1:0] forwardaE,
  output logic [1:0] forwardbE,
  output logic       forwardaD,
  output logic       forwardbD
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN,
    DIV_WAIT,
    MEM_WAIT
  } state_t;

  state_t        state, stateN;
  logic          excP, excPN;
  logic [CW-1:0] cnt, cntN;

  // r0 is hardwired zero, so it never creates a dependency
  function automatic logic hit(
    input logic [4:0] a,
    input logic [4:0] b
  );
    return (a != 5'd0) && (a == b);
  endfunction

  logic loadUse, brHaz, depHaz, dataHaz;
  logic [1:0] fwdAE, fwdBE;
  logic fwdAD, fwdBD;

  assign loadUse = MemtoRegE &
    (hit(writeregE, rsD) | hit(writeregE, rtD));

  assign brHaz = branchD & (
    (RegWriteE & (hit(writeregE, rsD) | hit(writeregE, rtD))) |
    (MemtoRegM & (hit(writeregM, rsD) | hit(writeregM, rtD))));

`ifdef HAZARD_FWD_EN
  assign depHaz = 1'b0;
  // M holds the younger result, so it takes precedence over W
  assign fwdAE = (RegWriteM & hit(writeregM, rsE)) ? 2'b10 :
                 (RegWriteW & hit(writeregW, rsE)) ? 2'b01 : 2'b00;
  assign fwdBE = (RegWriteM & hit(writeregM, rtE)) ? 2'b10 :
                 (RegWriteW & hit(writeregW, rtE)) ? 2'b01 : 2'b00;
  assign fwdAD = RegWriteM & hit(writeregM, rsD);
  assign fwdBD = RegWriteM & hit(writeregM, rtD);
`else
  logic unused;
  assign unused = ^{rsE, rtE};
  assign depHaz =
    (RegWriteE & (hit(writeregE, rsD) | hit(writeregE, rtD))) |
    (RegWriteM & (hit(writeregM, rsD) | hit(writeregM, rtD))) |
    (RegWriteW & (hit(writeregW, rsD) | hit(writeregW, rtD)));
  assign fwdAE = 2'b00;
  assign fwdBE = 2'b00;
  assign fwdAD = 1'b0;
  assign fwdBD = 1'b0;
`endif

  assign dataHaz = loadUse | brHaz | depHaz;

  logic stF, stD, stE, stM;
  logic flD, flE, flM, flW;
  logic dStart, dCancel, mTo;
  logic cntHit;

  assign cntHit = (cnt == CW'(MEM_TIMEOUT));

  always_comb begin
    stateN  = state;
    excPN   = excP;
    cntN    = cnt;
    stF     = 1'b0;
    stD     = 1'b0;
    stE     = 1'b0;
    stM     = 1'b0;
    flD     = 1'b0;
    flE     = 1'b0;
    flM     = 1'b0;
    flW     = 1'b0;
    dStart  = 1'b0;
    dCancel = 1'b0;
    mTo     = 1'b0;
    case (state)
      RUN: begin
        if (mem_req & ~mem_data_ok) begin
          {stF, stD, stE, stM} = 4'hF;
          flW    = 1'b1;
          stateN = MEM_WAIT;
          cntN   = '0;
          if (excM) excPN = 1'b1;
        end else if (excM) begin
          {flD, flE, flM, flW} = 4'hF;
        end else if (divE) begin
          dStart = 1'b1;
          if (!div_done) begin
            {stF, stD, stE} = 3'b111;
            flM    = 1'b1;
            stateN = DIV_WAIT;
          end
        end else if (dataHaz) begin
          stF = 1'b1;
          stD = 1'b1;
          flE = 1'b1;
        end
      end
      DIV_WAIT: begin
        if (excM) begin
          dCancel = 1'b1;
          {flD, flE, flM, flW} = 4'hF;
          stateN  = RUN;
        end else if (div_done) begin
          stateN = RUN;
        end else begin
          {stF, stD, stE} = 3'b111;
          flM = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_data_ok | cntHit) begin
          stateN = RUN;
          mTo    = ~mem_data_ok;
          // exception seen during the wait is applied once M drains
          if (excP) begin
            {flD, flE, flM, flW} = 4'hF;
            excPN = 1'b0;
          end
        end else begin
          {stF, stD, stE, stM} = 4'hF;
          flW  = 1'b1;
          cntN = cnt + 1'b1;
          if (excM) excPN = 1'b1;
        end
      end
      default: stateN = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      excP  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= stateN;
      excP  <= excPN;
      cnt   <= cntN;
    end
  end

  // everything is forced low while reset is held; flush beats stall
  assign div_start   = reset & dStart;
  assign div_cancel  = reset & dCancel;
  assign mem_timeout = reset & mTo;
  assign stallF      = reset & stF;
  assign stallD      = reset & stD & ~flD;
  assign stallE      = reset & stE & ~flE;
  assign stallM      = reset & stM & ~flM;
  assign stallW      = 1'b0;
  assign flushD      = reset & flD;
  assign flushE      = reset & flE;
  assign flushM      = reset & flM;
  assign flushW      = reset & flW;
  assign forwardaE   = reset ? fwdAE : 2'b00;
  assign forwardbE   = reset ? fwdBE : 2'b00;
  assign forwardaD   = reset & fwdAD;
  assign forwardbD   = reset & fwdBD;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors, corner sequences and a random
// run against a stage-level reference model of hazard_ctrl.
module tb_hazard_ctrl;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic branchD, divE, div_done, mem_req, mem_data_ok, excM;
  logic div_start, div_cancel, mem_timeout;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushD, flushE, flushM, flushW;
  logic [1:0] forwardaE, forwardbE;
  logic forwardaD, forwardbD;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .branchD(branchD), .divE(divE), .div_done(div_done),
    .mem_req(mem_req), .mem_data_ok(mem_data_ok), .excM(excM),
    .div_start(div_start), .div_cancel(div_cancel),
    .mem_timeout(mem_timeout),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .forwardaD(forwardaD), .forwardbD(forwardbD)
  );

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic rwE, rwM, rwW, m2rE, m2rM, br;
    logic divE, dDone, mReq, mOk, exc;
  } vin_t;

  typedef struct {
    string      nm;
    vin_t       v;
    logic [17:0] exp;
  } vec_t;

  logic [17:0] act;
  assign act = {div_start, div_cancel, mem_timeout,
                stallF, stallD, stallE, stallM, stallW,
                flushD, flushE, flushM, flushW,
                forwardaE, forwardbE, forwardaD, forwardbD};

  localparam logic [4:0] ST_HZ  = 5'b11000;
  localparam logic [4:0] ST_DIV = 5'b11100;
  localparam logic [4:0] ST_MEM = 5'b11110;
  localparam logic [3:0] FL_E   = 4'b0100;
  localparam logic [3:0] FL_M   = 4'b0010;
  localparam logic [3:0] FL_W   = 4'b0001;
  localparam logic [3:0] FL_ALL = 4'b1111;

  int nPass = 0;
  int nTot  = 0;
  vec_t tbl[$];

  function automatic logic [17:0] ev(
    input logic [2:0] c, input logic [4:0] s,
    input logic [3:0] f, input logic [5:0] w);
    return {c, s, f, w};
  endfunction

  function automatic vin_t idle();
    vin_t v;
    v.rsD = 0; v.rtD = 0; v.rsE = 0; v.rtE = 0;
    v.wE = 0; v.wM = 0; v.wW = 0;
    v.rwE = 0; v.rwM = 0; v.rwW = 0; v.m2rE = 0; v.m2rM = 0;
    v.br = 0; v.divE = 0; v.dDone = 0;
    v.mReq = 0; v.mOk = 0; v.exc = 0;
    return v;
  endfunction

  task automatic drive(input vin_t v);
    rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    writeregE = v.wE; writeregM = v.wM; writeregW = v.wW;
    RegWriteE = v.rwE; RegWriteM = v.rwM; RegWriteW = v.rwW;
    MemtoRegE = v.m2rE; MemtoRegM = v.m2rM; branchD = v.br;
    divE = v.divE; div_done = v.dDone;
    mem_req = v.mReq; mem_data_ok = v.mOk; excM = v.exc;
  endtask

  task automatic chk(input string nm, input logic [17:0] exp);
    nTot++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)",
                  nm, act, exp, $time);
  endtask

  task automatic add(input string nm, input vin_t v,
                     input logic [17:0] exp);
    vec_t e;
    e.nm = nm; e.v = v; e.exp = exp;
    tbl.push_back(e);
  endtask

  task automatic cyc(input vin_t v, input string nm,
                     input logic [17:0] exp);
    @(negedge clk);
    drive(v);
    #1;
    chk(nm, exp);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    drive(idle());
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // mode: 0 running, 1 waiting on divider, 2 waiting on memory
  int mMode = 0, mWait = 0;
  bit mPend = 0;
  int nMode, nWait;
  bit nPend;

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  task automatic model(input vin_t v, input logic rst,
                       output logic [17:0] exp);
    int frz;
    bit bub[5];
    bit s[5];
    bit ds, dc, mt, haz, rel;
    logic [1:0] aE, bE;
    bit aD, bD;
    frz = 0; ds = 0; dc = 0; mt = 0;
    foreach (bub[i]) bub[i] = 0;
    aE = 0; bE = 0; aD = 0; bD = 0;
    nMode = mMode; nWait = mWait; nPend = mPend;
    haz = (v.m2rE && (hit(v.wE, v.rsD) || hit(v.wE, v.rtD))) ||
          (v.br && ((v.rwE && (hit(v.wE, v.rsD) || hit(v.wE, v.rtD))) ||
                    (v.m2rM && (hit(v.wM, v.rsD) || hit(v.wM, v.rtD)))));
`ifdef HAZARD_FWD_EN
    if (v.rwM && hit(v.wM, v.rsE)) aE = 2;
    else if (v.rwW && hit(v.wW, v.rsE)) aE = 1;
    if (v.rwM && hit(v.wM, v.rtE)) bE = 2;
    else if (v.rwW && hit(v.wW, v.rtE)) bE = 1;
    aD = v.rwM && hit(v.wM, v.rsD);
    bD = v.rwM && hit(v.wM, v.rtD);
`else
    haz = haz ||
      (v.rwE && (hit(v.wE, v.rsD) || hit(v.wE, v.rtD))) ||
      (v.rwM && (hit(v.wM, v.rsD) || hit(v.wM, v.rtD))) ||
      (v.rwW && (hit(v.wW, v.rsD) || hit(v.wW, v.rtD)));
`endif
    if (mMode == 0) begin
      if (v.mReq && !v.mOk) begin
        frz = 4; bub[4] = 1; nMode = 2; nWait = 0;
        if (v.exc) nPend = 1;
      end else if (v.exc) begin
        for (int i = 1; i < 5; i++) bub[i] = 1;
      end else if (v.divE) begin
        ds = 1;
        if (!v.dDone) begin
          frz = 3; bub[3] = 1; nMode = 1;
        end
      end else if (haz) begin
        frz = 2; bub[2] = 1;
      end
    end else if (mMode == 1) begin
      if (v.exc) begin
        dc = 1; nMode = 0;
        for (int i = 1; i < 5; i++) bub[i] = 1;
      end else if (v.dDone) begin
        nMode = 0;
      end else begin
        frz = 3; bub[3] = 1;
      end
    end else begin
      rel = v.mOk || (mWait == TMO);
      if (rel) begin
        nMode = 0;
        mt = !v.mOk;
        if (mPend) begin
          for (int i = 1; i < 5; i++) bub[i] = 1;
          nPend = 0;
        end
      end else begin
        frz = 4; bub[4] = 1; nWait = mWait + 1;
        if (v.exc) nPend = 1;
      end
    end
    for (int i = 0; i < 5; i++) s[i] = (i < frz) && !bub[i];
    exp = {ds, dc, mt, s[0], s[1], s[2], s[3], s[4],
           bub[1], bub[2], bub[3], bub[4], aE, bE, aD, bD};
    if (!rst) begin
      exp = '0;
      mMode = 0; mWait = 0; mPend = 0;
      nMode = 0; nWait = 0; nPend = 0;
    end
  endtask

  function automatic vin_t rnd();
    vin_t v;
    v.rsD = 5'($urandom_range(0, 3)); v.rtD = 5'($urandom_range(0, 3));
    v.rsE = 5'($urandom_range(0, 3)); v.rtE = 5'($urandom_range(0, 3));
    v.wE = 5'($urandom_range(0, 3)); v.wM = 5'($urandom_range(0, 3));
    v.wW = 5'($urandom_range(0, 3));
    v.rwE = 1'($urandom_range(0, 1)); v.rwM = 1'($urandom_range(0, 1));
    v.rwW = 1'($urandom_range(0, 1));
    v.m2rE = ($urandom_range(0, 2) == 0);
    v.m2rM = ($urandom_range(0, 2) == 0);
    v.br = ($urandom_range(0, 2) == 0);
    v.divE = ($urandom_range(0, 4) == 0);
    v.dDone = ($urandom_range(0, 3) == 0);
    v.mReq = ($urandom_range(0, 3) == 0);
    v.mOk = ($urandom_range(0, 2) == 0);
    v.exc = ($urandom_range(0, 9) == 0);
    return v;
  endfunction

  initial begin
    vin_t v;
    logic [17:0] e;

    // reset state: outputs forced low even with busy inputs
    v = idle();
    v.divE = 1; v.exc = 1; v.mReq = 1; v.rwM = 1; v.wM = 3; v.rsE = 3;
    reset = 1'b0;
    drive(v);
    #2;
    chk("reset_state", 18'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(idle());

    // ---------------- table vectors from RUN ----------------
    v = idle();
    add("idle", v, 18'd0);
    v = idle(); v.m2rE = 1; v.rwE = 1; v.wE = 8; v.rsD = 8;
    add("loaduse_rs", v, ev(0, ST_HZ, FL_E, 0));
    v = idle(); v.m2rE = 1; v.rwE = 1;
    add("loaduse_r0", v, 18'd0);
    v = idle(); v.m2rE = 1; v.wE = 9; v.rtD = 9;
    add("loaduse_rt", v, ev(0, ST_HZ, FL_E, 0));
    v = idle(); v.exc = 1;
    add("exc_flush", v, ev(0, 0, FL_ALL, 0));
    v = idle(); v.mReq = 1;
    add("mem_miss", v, ev(0, ST_MEM, FL_W, 0));
    v = idle(); v.mReq = 1; v.mOk = 1;
    add("mem_hit", v, 18'd0);
    v = idle(); v.mReq = 1; v.exc = 1;
    add("mem_over_exc", v, ev(0, ST_MEM, FL_W, 0));
    v = idle(); v.exc = 1; v.divE = 1;
    add("exc_over_div", v, ev(0, 0, FL_ALL, 0));
    v = idle(); v.divE = 1;
    add("div_launch", v, ev(3'b100, ST_DIV, FL_M, 0));
    v = idle(); v.divE = 1; v.dDone = 1;
    add("div_done_now", v, ev(3'b100, 0, 0, 0));
    v = idle(); v.divE = 1; v.m2rE = 1; v.wE = 8; v.rsD = 8;
    add("div_over_lu", v, ev(3'b100, ST_DIV, FL_M, 0));
    v = idle(); v.br = 1; v.rwE = 1; v.wE = 5; v.rsD = 5;
    add("branch_E", v, ev(0, ST_HZ, FL_E, 0));
    v = idle(); v.br = 1; v.m2rM = 1; v.wM = 6; v.rtD = 6;
    add("branch_M", v, ev(0, ST_HZ, FL_E, 0));
    v = idle(); v.br = 1; v.rwE = 1;
    add("branch_r0", v, 18'd0);
    v = idle(); v.rwM = 1; v.wM = 0;
    add("fwd_r0", v, 18'd0);
`ifdef HAZARD_FWD_EN
    v = idle(); v.rwW = 1; v.wW = 7; v.rsD = 7;
    add("dep_W", v, 18'd0);
    v = idle(); v.rwM = 1; v.wM = 3; v.rsE = 3;
    v.rwW = 1; v.wW = 4; v.rtE = 4;
    add("fwd_E", v, ev(0, 0, 0, 6'b10_01_00));
    v = idle(); v.rwM = 1; v.wM = 2; v.rwW = 1; v.wW = 2;
    v.rsE = 2; v.rtE = 2;
    add("fwd_M_beats_W", v, ev(0, 0, 0, 6'b10_10_00));
    v = idle(); v.rwM = 1; v.wM = 3; v.rsD = 3;
    add("dep_M_D", v, ev(0, 0, 0, 6'b00_00_10));
`else
    v = idle(); v.rwW = 1; v.wW = 7; v.rsD = 7;
    add("dep_W", v, ev(0, ST_HZ, FL_E, 0));
    v = idle(); v.rwM = 1; v.wM = 3; v.rsE = 3;
    v.rwW = 1; v.wW = 4; v.rtE = 4;
    add("fwd_E", v, 18'd0);
    v = idle(); v.rwM = 1; v.wM = 2; v.rwW = 1; v.wW = 2;
    v.rsE = 2; v.rtE = 2;
    add("fwd_M_beats_W", v, 18'd0);
    v = idle(); v.rwM = 1; v.wM = 3; v.rsD = 3;
    add("dep_M_D", v, ev(0, ST_HZ, FL_E, 0));
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v);
      #1;
      chk(tbl[i].nm, tbl[i].exp);
      reset = 1'b0;
      #1;
      reset = 1'b1;
      drive(idle());
    end

    // ---------------- divide, done 5 cycles later ----------------
    pulseReset();
    v = idle(); v.divE = 1;
    cyc(v, "div_start", ev(3'b100, ST_DIV, FL_M, 0));
    for (int k = 1; k < 5; k++)
      cyc(v, "div_hold", ev(0, ST_DIV, FL_M, 0));
    v.dDone = 1;
    cyc(v, "div_release", 18'd0);
    cyc(idle(), "div_after", 18'd0);

    // ---------------- memory wait with exception ----------------
    v = idle(); v.mReq = 1;
    cyc(v, "mem_enter", ev(0, ST_MEM, FL_W, 0));
    cyc(v, "mem_wait", ev(0, ST_MEM, FL_W, 0));
    v.exc = 1;
    cyc(v, "mem_exc_held", ev(0, ST_MEM, FL_W, 0));
    v.exc = 0; v.mOk = 1;
    cyc(v, "mem_release_flush", ev(0, 0, FL_ALL, 0));
    cyc(idle(), "mem_after", 18'd0);

    // ---------------- timeout ----------------
    v = idle(); v.mReq = 1;
    cyc(v, "to_enter", ev(0, ST_MEM, FL_W, 0));
    for (int k = 0; k < TMO; k++)
      cyc(v, "to_wait", ev(0, ST_MEM, FL_W, 0));
    cyc(v, "to_release", ev(3'b001, 0, 0, 0));
    cyc(idle(), "to_after", 18'd0);

    // ---------------- exception beats div_done ----------------
    v = idle(); v.divE = 1;
    cyc(v, "dx_start", ev(3'b100, ST_DIV, FL_M, 0));
    v.exc = 1; v.dDone = 1;
    cyc(v, "dx_cancel", ev(3'b010, 0, FL_ALL, 0));
    v = idle(); v.divE = 1;
    cyc(v, "dx_back_in_run", ev(3'b100, ST_DIV, FL_M, 0));
    v.dDone = 1;
    cyc(v, "dx_done", 18'd0);

    // ---------------- reset mid divide wait ----------------
    v = idle(); v.divE = 1;
    cyc(v, "rst_div_start", ev(3'b100, ST_DIV, FL_M, 0));
    cyc(v, "rst_div_hold", ev(0, ST_DIV, FL_M, 0));
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_immediate", 18'd0);
    @(posedge clk);
    #1;
    chk("rst_held", 18'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(idle());
    #1;
    chk("rst_released", 18'd0);
    cyc(v, "rst_run_again", ev(3'b100, ST_DIV, FL_M, 0));
    v.dDone = 1;
    cyc(v, "rst_div_done", 18'd0);

    // ---------------- load-use then forward ----------------
    v = idle(); v.m2rE = 1; v.rwE = 1; v.wE = 8; v.rsD = 8;
    cyc(v, "lu_stall", ev(0, ST_HZ, FL_E, 0));
    v = idle(); v.rsE = 8; v.wM = 8; v.rwM = 1; v.m2rM = 1;
`ifdef HAZARD_FWD_EN
    cyc(v, "lu_forward", ev(0, 0, 0, 6'b10_00_00));
`else
    cyc(v, "lu_forward", 18'd0);
`endif

    // ---------------- random vs reference model ----------------
    pulseReset();
    mMode = 0; mWait = 0; mPend = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      v = rnd();
      reset = ($urandom_range(0, 99) != 0);
      drive(v);
      #1;
      model(v, reset, e);
      chk("random", e);
      @(posedge clk);
      mMode = nMode; mWait = nWait; mPend = nPend;
    end

    $display("%0d/%0d checks passed", nPass, nTot);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS-32 core. It computes the stall and flush controls consumed by every pipeline register: stallF/D/E/M/W and flushD/E/M/W, including the stallE/flush pair that freezes or bubbles the D/E register. It also generates the E- and D-stage forwarding selects. It owns the multi-cycle waits: the divider start/done handshake, the data-memory data_ok wait with timeout, and exception flush ordering.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum number of MEM_WAIT cycles before the timeout release.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- rsD, rtD, rsE, rtE  in  5 each  source register numbers in D and E.
- writeregE, writeregM, writeregW  in  5 each  destination registers.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  destination-write enables.
- MemtoRegE, MemtoRegM  in  1 each  load in E or M.
- branchD  in  1  branch or jr in D that needs its operands in D.
- divE  in  1  div/divu in E.
- div_done  in  1  divider result valid (single-cycle pulse).
- mem_req  in  1  data access pending in M.
- mem_data_ok  in  1  data access complete.
- excM  in  1  exception or eret committing in M.
- div_start  out  1  one-cycle divider launch.
- div_cancel  out  1  one-cycle divider abort.
- mem_timeout  out  1  one-cycle pulse on timeout release.
- stallF, stallD, stallE, stallM, stallW  out  1 each  hold the corresponding register.
- flushD, flushE, flushM, flushW  out  1 each  clear the corresponding register.
- forwardaE, forwardbE  out  2 each  E-stage forwarding: 00 register file, 01 W, 10 M.
- forwardaD, forwardbD  out  1 each  D-stage forwarding from M.

## Operation
- State machine states: RUN, DIV_WAIT, MEM_WAIT. A 1-bit pending-exception flag excP. A timeout counter of width clog2(MEM_TIMEOUT+1).
- Reset (reset=0): state RUN, excP 0, counter 0. While reset is low every output is 0.
- Register 0 never matches in any comparison.
- Priority in RUN: MEM > exception > DIV > load-use/branch.
- RUN, mem_req & !mem_data_ok:
  - Assert stallF, stallD, stallE, stallM and flushW.
  - Next state MEM_WAIT. Counter clears.
  - If excM is also 1, set excP.
- RUN, excM without a memory wait:
  - Assert flushD, flushE, flushM, flushW in the same cycle.
  - No stalls are asserted.
- RUN, divE:
  - Assert div_start, stallF, stallD, stallE and flushM.
  - Next state DIV_WAIT.
  - If div_done is already 1 in this cycle, stay in RUN and release.
- DIV_WAIT:
  - Hold the same stalls and flushM.
  - On div_done: release the stalls that cycle; next state RUN.
  - On excM: assert div_cancel and all four flushes; next state RUN. excM wins over div_done in the same cycle.
- MEM_WAIT:
  - Hold stallF–M and flushW. The counter increments each cycle.
  - Set excP if excM arrives.
  - On mem_data_ok, or when the counter reaches MEM_TIMEOUT: release the stalls; next state RUN. The timeout release also pulses mem_timeout.
  - If excP is set at release: assert the four flushes that cycle and clear excP.
- Load-use (RUN only): MemtoRegE & (writeregE==rsD | writeregE==rtD).
  - Assert stallF, stallD, flushE.
- Branch hazard (RUN only): branchD & ((RegWriteE & writeregE matches rsD or rtD) | (MemtoRegM & writeregM matches rsD or rtD)).
  - Assert stallF, stallD, flushE.
- A flush overrides a stall on the same register.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and current state; there is zero-cycle latency to the pipeline registers.
- div_start is high for exactly one cycle per divide. The minimum divide bubble is 1 cycle when div_done arrives in the cycle after div_start.
- Memory wait releases in the cycle mem_data_ok is 1. The maximum MEM_WAIT dwell is MEM_TIMEOUT+1 cycles.
- State, excP and counter update on the rising edge of clk. Reset acts immediately and asynchronously, including mid-wait. div_cancel is not issued on reset.

## Configuration
- HAZARD_FWD_EN defined:
  - forwardaE/forwardbE: M beats W (RegWrite & register match).
  - forwardaD/forwardbD = RegWriteM & writeregM==rsD (a) or rtD (b).
  - Stalls only for load-use and the branch hazard.
- HAZARD_FWD_EN undefined:
  - All forward outputs are constant 0.
  - Any RegWrite E/M/W destination matching rsD or rtD asserts stallF, stallD, flushE.

## Test plan
- Load-use: MemtoRegE=1, writeregE=8, rsD=8 -> stallF=stallD=flushE=1 for 1 cycle; with HAZARD_FWD_EN, forwardaE=10 the following cycle.
- Divide: divE=1, div_done 5 cycles later -> div_start pulses once; stallE=1 for 5 cycles; released in the div_done cycle.
- Memory wait: mem_req=1, mem_data_ok after 3 cycles, excM in cycle 2 -> no flush until the release cycle; flushD–W=1 in the data_ok cycle.
- Timeout: MEM_TIMEOUT=4, mem_data_ok never -> mem_timeout pulses once; stallM drops after 5 wait cycles.
- Exception with done: excM=1 and div_done=1 together in DIV_WAIT -> div_cancel=1 and all flushes=1; state returns to RUN.
- Reset: drop reset mid-DIV_WAIT -> all outputs 0 immediately; state RUN after reset deasserts.
